// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one single-ported memory between an instruction-fetch
//               requester (IF) and a data requester (DM). Data wins ties,
//               except that once MAX_D_STREAK consecutive data grants have
//               been issued while a fetch waits, the fetch is served next.
//               One access is in flight at a time: IDLE -> GRANT_x -> RESP.
//
// Ports       : clk, reset            clock / synchronous active-high reset
//               if_req, if_addr       fetch request (level) and address
//               if_rdata, if_valid    fetched word and completion pulse
//               dm_req, dm_we,        data request (level), write flag,
//               dm_addr, dm_wdata,    address, write data,
//               dm_be                 byte enables
//               dm_rdata, dm_valid    load data and completion pulse
//               mem_req, mem_we,      memory command, held stable for the
//               mem_addr, mem_wdata,  whole grant
//               mem_be
//               mem_ready, mem_rdata  memory handshake and read data
//               stall_if, stall_mem   pipeline hold requests
//
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MAX_D_STREAK = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_valid,
    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W-1:0]   dm_wdata,
    input  logic [DATA_W/8-1:0] dm_be,
    output logic [DATA_W-1:0]   dm_rdata,
    output logic                dm_valid,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic                mem_ready,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                stall_if,
    output logic                stall_mem
);

    localparam int c_BE_W     = DATA_W / 8;
    localparam int c_STREAK_W = $clog2(MAX_D_STREAK + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [c_STREAK_W-1:0]   r_streak;
    logic                    w_streak_ok;
    logic                    w_pick_d;
    logic                    w_pick_i;

    logic                    r_mem_we;
    logic [ADDR_W-1:0]       r_mem_addr;
    logic [DATA_W-1:0]       r_mem_wdata;
    logic [c_BE_W-1:0]       r_mem_be;
    logic                    r_if_valid;
    logic                    r_dm_valid;
    logic [DATA_W-1:0]       r_if_rdata;
    logic [DATA_W-1:0]       r_dm_rdata;

    // Data may keep winning only while the streak is below its limit.
    assign w_streak_ok = (r_streak < c_STREAK_W'(MAX_D_STREAK));

    // ------------------------------------------------------------------
    // Next-state / arbitration decision
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_pick_d    = 1'b0;
        w_pick_i    = 1'b0;
        case (r_state)
            IDLE: begin
                if (dm_req && (!if_req || w_streak_ok)) begin
                    w_pick_d    = 1'b1;
                    w_state_nxt = GRANT_D;
                end else if (if_req) begin
                    w_pick_i    = 1'b1;
                    w_state_nxt = GRANT_I;
                end
            end
            GRANT_I, GRANT_D: begin
                if (mem_ready) begin
                    w_state_nxt = RESP;
                end
            end
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Command latch, response capture and streak tracking
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_streak    <= '0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_be    <= '0;
            r_if_valid  <= 1'b0;
            r_dm_valid  <= 1'b0;
            r_if_rdata  <= '0;
            r_dm_rdata  <= '0;
        end else begin
            // Valid pulses are high exactly for the RESP cycle.
            r_if_valid <= (r_state == GRANT_I) && mem_ready;
            r_dm_valid <= (r_state == GRANT_D) && mem_ready;

            // The command is captured only at the decision, so requester
            // inputs moving during the grant cannot disturb it.
            if (w_pick_d) begin
                r_mem_we    <= dm_we;
                r_mem_addr  <= dm_addr;
                r_mem_wdata <= dm_wdata;
                r_mem_be    <= dm_be;
                if (!if_req) begin
                    r_streak <= '0;
                end else if (w_streak_ok) begin
                    r_streak <= r_streak + c_STREAK_W'(1);
                end
            end else if (w_pick_i) begin
                r_mem_we    <= 1'b0;
                r_mem_addr  <= if_addr;
                r_mem_wdata <= '0;
                r_mem_be    <= '1;
                r_streak    <= '0;
            end

            if ((r_state == GRANT_I) && mem_ready) begin
                r_if_rdata <= mem_rdata;
            end
            // Stores complete without touching the load-data register.
            if ((r_state == GRANT_D) && mem_ready && !r_mem_we) begin
                r_dm_rdata <= mem_rdata;
            end
        end
    end

    assign mem_req   = (r_state == GRANT_I) || (r_state == GRANT_D);
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_be    = r_mem_be;
    assign if_valid  = r_if_valid;
    assign dm_valid  = r_dm_valid;
    assign if_rdata  = r_if_rdata;
    assign dm_rdata  = r_dm_rdata;

    assign stall_if  = if_req & ~r_if_valid;
    assign stall_mem = dm_req & ~r_dm_valid;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed self-checking bench for mem_port_arbiter. A small
//               memory model answers each grant after a programmable delay;
//               expected commands and responses are queued as stimulus is
//               applied and popped when the DUT issues a grant or a valid.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int c_ADDR_W = 32;
    localparam int c_DATA_W = 32;
    localparam int c_MAXD   = 4;

    logic                    clk       = 1'b0;
    logic                    reset     = 1'b1;
    logic                    if_req    = 1'b0;
    logic [c_ADDR_W-1:0]     if_addr   = '0;
    logic [c_DATA_W-1:0]     if_rdata;
    logic                    if_valid;
    logic                    dm_req    = 1'b0;
    logic                    dm_we     = 1'b0;
    logic [c_ADDR_W-1:0]     dm_addr   = '0;
    logic [c_DATA_W-1:0]     dm_wdata  = '0;
    logic [c_DATA_W/8-1:0]   dm_be     = '0;
    logic [c_DATA_W-1:0]     dm_rdata;
    logic                    dm_valid;
    logic                    mem_req;
    logic                    mem_we;
    logic [c_ADDR_W-1:0]     mem_addr;
    logic [c_DATA_W-1:0]     mem_wdata;
    logic [c_DATA_W/8-1:0]   mem_be;
    logic                    mem_ready = 1'b0;
    logic [c_DATA_W-1:0]     mem_rdata = '0;
    logic                    stall_if;
    logic                    stall_mem;

    mem_port_arbiter #(
        .ADDR_W       (c_ADDR_W),
        .DATA_W       (c_DATA_W),
        .MAX_D_STREAK (c_MAXD)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_valid  (if_valid),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_be     (dm_be),
        .dm_rdata  (dm_rdata),
        .dm_valid  (dm_valid),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .stall_if  (stall_if),
        .stall_mem (stall_mem)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        bit          chk_wdata;
    } cmd_t;

    typedef struct {
        bit          is_d;
        logic [31:0] if_rd;
        logic [31:0] dm_rd;
    } resp_t;

    cmd_t        cmd_q[$];
    resp_t       resp_q[$];
    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] model_if = '0;
    logic [31:0] model_dm = '0;

    // Memory contents as seen by the bench.
    function automatic logic [31:0] rdata_of(input logic [31:0] a);
        if (a == 32'h100) return 32'h0050_0093;
        return (a * 32'd2654435761) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_cmd(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] be, input bit chk_wdata);
        cmd_t c;
        c.we = we; c.addr = addr; c.wdata = wdata; c.be = be; c.chk_wdata = chk_wdata;
        cmd_q.push_back(c);
    endtask

    task automatic push_resp(input bit is_d, input logic we, input logic [31:0] addr);
        resp_t r;
        if (is_d && !we) model_dm = rdata_of(addr);
        if (!is_d)       model_if = rdata_of(addr);
        r.is_d = is_d; r.if_rd = model_if; r.dm_rd = model_dm;
        resp_q.push_back(r);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_mem_req"},   64'(mem_req),   64'd0);
        check({pfx, "_mem_we"},    64'(mem_we),    64'd0);
        check({pfx, "_mem_addr"},  64'(mem_addr),  64'd0);
        check({pfx, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
        check({pfx, "_mem_be"},    64'(mem_be),    64'd0);
        check({pfx, "_if_valid"},  64'(if_valid),  64'd0);
        check({pfx, "_dm_valid"},  64'(dm_valid),  64'd0);
        check({pfx, "_if_rdata"},  64'(if_rdata),  64'd0);
        check({pfx, "_dm_rdata"},  64'(dm_rdata),  64'd0);
    endtask

    // ------------------------------------------------------------------
    // Monitor + memory model (negedge, away from the active edge)
    // ------------------------------------------------------------------
    int   mem_lat     = 2;
    bit   mem_auto    = 1'b1;
    bit   force_ready = 1'b0;
    int   busy_cnt    = 0;
    logic prev_req    = 1'b0;
    cmd_t cur;

    always @(negedge clk) begin
        if (mem_req && !prev_req) begin
            if (cmd_q.size() == 0) begin
                check("unexpected_grant", 64'(mem_req), 64'd0);
            end else begin
                cur = cmd_q.pop_front();
                check("cmd_we",   64'(mem_we),   64'(cur.we));
                check("cmd_addr", 64'(mem_addr), 64'(cur.addr));
                check("cmd_be",   64'(mem_be),   64'(cur.be));
                if (cur.chk_wdata) check("cmd_wdata", 64'(mem_wdata), 64'(cur.wdata));
            end
        end else if (mem_req && prev_req) begin
            check("stable_addr", 64'(mem_addr), 64'(cur.addr));
            check("stable_we_be", 64'({mem_we, mem_be}), 64'({cur.we, cur.be}));
            if (cur.chk_wdata) check("stable_wdata", 64'(mem_wdata), 64'(cur.wdata));
        end
        prev_req = mem_req;

        if (if_valid || dm_valid) begin
            if (resp_q.size() == 0) begin
                check("unexpected_valid", 64'({if_valid, dm_valid}), 64'd0);
            end else begin
                resp_t e;
                e = resp_q.pop_front();
                check("valid_which", 64'({dm_valid, if_valid}), e.is_d ? 64'd2 : 64'd1);
                check("resp_if_rdata", 64'(if_rdata), 64'(e.if_rd));
                check("resp_dm_rdata", 64'(dm_rdata), 64'(e.dm_rd));
            end
        end

        if (!mem_auto) begin
            mem_ready = force_ready;
            mem_rdata = 32'hFFFF_FFFF;
        end else if (mem_req && !mem_ready) begin
            busy_cnt = busy_cnt + 1;
            if (busy_cnt >= mem_lat) begin
                mem_ready = 1'b1;
                mem_rdata = rdata_of(mem_addr);
            end
        end else begin
            mem_ready = 1'b0;
            busy_cnt  = 0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    initial begin
        int req_cycles, lat, di;
        bit got, stall_ok, d_seen, i_seen, order_ok, changed;
        logic [31:0] st_addr [6];
        logic [31:0] st_data [6];

        // Reset state
        reset = 1'b1;
        tick(); tick();
        check_all_zero("reset");
        reset = 1'b0;
        tick();

        // Single fetch, 2-cycle memory
        mem_lat = 2;
        push_cmd(1'b0, 32'h100, 32'h0, 4'hF, 1'b0);
        push_resp(1'b0, 1'b0, 32'h100);
        if_addr = 32'h100; if_req = 1'b1;
        #1;
        check("fetch_stall_if_start", 64'(stall_if), 64'd1);
        req_cycles = 0; lat = 0; got = 1'b0; stall_ok = 1'b1;
        for (int c = 0; c < 20 && !got; c++) begin
            tick();
            lat++;
            if (mem_req) req_cycles++;
            if (if_valid) begin
                got = 1'b1;
                check("fetch_stall_if_at_valid", 64'(stall_if), 64'd0);
                if_req = 1'b0;
            end else if (!stall_if) begin
                stall_ok = 1'b0;
            end
        end
        check("fetch_done", 64'(got), 64'd1);
        check("fetch_mem_req_cycles", 64'(req_cycles), 64'd2);
        check("fetch_latency", 64'(lat), 64'd3);
        check("fetch_stall_held", 64'(stall_ok), 64'd1);
        check("fetch_if_rdata", 64'(if_rdata), 64'h0050_0093);
        tick(); tick();

        // Simultaneous fetch + load: data first
        dm_we = 1'b0; dm_addr = 32'h200; dm_wdata = 32'hCAFE_0000; dm_be = 4'hF;
        push_cmd(1'b0, 32'h200, 32'hCAFE_0000, 4'hF, 1'b1);
        push_cmd(1'b0, 32'h140, 32'h0, 4'hF, 1'b0);
        push_resp(1'b1, 1'b0, 32'h200);
        push_resp(1'b0, 1'b0, 32'h140);
        dm_req = 1'b1; if_addr = 32'h140; if_req = 1'b1;
        #1;
        check("sim_stall_mem_start", 64'(stall_mem), 64'd1);
        d_seen = 1'b0; i_seen = 1'b0; order_ok = 1'b1; stall_ok = 1'b1;
        for (int c = 0; c < 40 && !i_seen; c++) begin
            tick();
            if (dm_valid) begin d_seen = 1'b1; dm_req = 1'b0; end
            if (if_valid) begin
                i_seen = 1'b1;
                if (!d_seen) order_ok = 1'b0;
                if_req = 1'b0;
            end else if (!stall_if) begin
                stall_ok = 1'b0;
            end
        end
        check("sim_both_done", 64'({d_seen, i_seen}), 64'd3);
        check("sim_data_first", 64'(order_ok), 64'd1);
        check("sim_stall_if_held", 64'(stall_ok), 64'd1);
        tick(); tick();

        // Starvation guard: 6 stores vs a held fetch -> D,D,D,D,I,D,D
        for (int i = 0; i < 6; i++) begin
            st_addr[i] = 32'h400 + 32'(i * 4);
            st_data[i] = 32'h1000_0000 + 32'(i * 32'h111);
        end
        for (int i = 0; i < 4; i++) push_cmd(1'b1, st_addr[i], st_data[i], 4'hF, 1'b1);
        push_cmd(1'b0, 32'h180, 32'h0, 4'hF, 1'b0);
        for (int i = 4; i < 6; i++) push_cmd(1'b1, st_addr[i], st_data[i], 4'hF, 1'b1);
        for (int i = 0; i < 4; i++) push_resp(1'b1, 1'b1, st_addr[i]);
        push_resp(1'b0, 1'b0, 32'h180);
        for (int i = 4; i < 6; i++) push_resp(1'b1, 1'b1, st_addr[i]);
        di = 0;
        dm_we = 1'b1; dm_addr = st_addr[0]; dm_wdata = st_data[0]; dm_be = 4'hF; dm_req = 1'b1;
        if_addr = 32'h180; if_req = 1'b1;
        for (int c = 0; c < 200 && (di < 6 || if_req); c++) begin
            tick();
            if (dm_valid) begin
                di++;
                if (di < 6) begin
                    dm_addr = st_addr[di]; dm_wdata = st_data[di];
                end else begin
                    dm_req = 1'b0;
                end
            end
            if (if_valid) if_req = 1'b0;
        end
        check("starve_stores_done", 64'(di), 64'd6);
        check("starve_fetch_done", 64'(if_req), 64'd0);
        check("starve_dm_rdata_held", 64'(dm_rdata), 64'(rdata_of(32'h200)));
        tick(); tick();

        // Store with inputs changing mid-grant
        mem_lat = 3;
        dm_we = 1'b1; dm_addr = 32'h300; dm_wdata = 32'hDEAD_BEEF; dm_be = 4'b0011;
        push_cmd(1'b1, 32'h300, 32'hDEAD_BEEF, 4'b0011, 1'b1);
        push_resp(1'b1, 1'b1, 32'h300);
        dm_req = 1'b1;
        got = 1'b0; changed = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            tick();
            if (mem_req && !changed) begin
                dm_addr = 32'h999; dm_wdata = 32'h0; dm_be = 4'hC; changed = 1'b1;
            end
            if (dm_valid) begin got = 1'b1; dm_req = 1'b0; end
        end
        check("store_done", 64'(got), 64'd1);
        check("store_dm_rdata_unchanged", 64'(dm_rdata), 64'(rdata_of(32'h200)));
        tick(); tick();

        // Reset in the middle of a stuck data grant
        mem_lat = 1000;
        dm_we = 1'b0; dm_addr = 32'h500; dm_wdata = 32'h1111_2222; dm_be = 4'hF;
        push_cmd(1'b0, 32'h500, 32'h1111_2222, 4'hF, 1'b1);
        dm_req = 1'b1;
        for (int c = 0; c < 10 && !mem_req; c++) tick();
        check("rst_grant_d_active", 64'(mem_req), 64'd1);
        if_addr = 32'h1C0; if_req = 1'b1;
        tick(); tick();
        dm_req = 1'b0; reset = 1'b1;
        tick();
        check_all_zero("midrst");
        resp_q.delete();
        model_if = '0; model_dm = '0;
        mem_lat = 2;
        push_cmd(1'b0, 32'h1C0, 32'h0, 4'hF, 1'b0);
        push_resp(1'b0, 1'b0, 32'h1C0);
        reset = 1'b0;
        tick();
        check("rst_fetch_granted_next", 64'(mem_req), 64'd1);
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            tick();
            if (if_valid) begin got = 1'b1; if_req = 1'b0; end
        end
        check("rst_fetch_done", 64'(got), 64'd1);
        tick(); tick();

        // Spurious mem_ready in IDLE
        mem_auto = 1'b0; force_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("spurious_quiet", 64'({mem_req, if_valid, dm_valid}), 64'd0);
        end
        force_ready = 1'b0;
        tick();
        mem_auto = 1'b1;
        tick();
        check("spurious_if_rdata", 64'(if_rdata), 64'(rdata_of(32'h1C0)));
        check("spurious_dm_rdata", 64'(dm_rdata), 64'd0);

        tick(); tick();
        check("queues_empty", 64'(cmd_q.size() + resp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
